// File: rtl/vend_dispense_if.sv
// Handshake bundle between the vending FSM / actuator side and vend_dispense_ctrl.
// COIN_COUNT_EN adds the coins_paid counter output.
interface vend_dispense_if #(
    parameter int CAMBIO_W = 5
);
    logic                listo;
    logic [1:0]          producto;
    logic [CAMBIO_W-1:0] cambio;
    logic [2:0]          hopper_empty;
    logic                coin_ack;
    logic                clear_fault;
    logic [2:0]          motor_en;
    logic [2:0]          coin_eject;
    logic                busy;
    logic                done;
    logic                fault;
    logic [CAMBIO_W-1:0] pendiente;
`ifdef COIN_COUNT_EN
    logic [7:0]          coins_paid;
`endif

    modport master (
        output listo, producto, cambio, hopper_empty, coin_ack, clear_fault,
        input  motor_en, coin_eject, busy, done, fault, pendiente
`ifdef COIN_COUNT_EN
        , input coins_paid
`endif
    );

    modport slave (
        input  listo, producto, cambio, hopper_empty, coin_ack, clear_fault,
        output motor_en, coin_eject, busy, done, fault, pendiente
`ifdef COIN_COUNT_EN
        , output coins_paid
`endif
    );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Product motor and greedy change-payout sequencer (4/2/1 hoppers, per-coin ack with timeout).
// Optional macro COIN_COUNT_EN adds a saturating count of accepted coins on coins_paid.
module vend_dispense_ctrl #(
    parameter int CAMBIO_W     = 5,
    parameter int MOTOR_CYCLES = 8,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    vend_dispense_if.slave   bus
);
    localparam int MOT_W = $clog2(MOTOR_CYCLES + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MOTOR    = 3'd1,
        ST_SELECT   = 3'd2,
        ST_EJECT    = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_DONE     = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    state_t              state_r, state_s;
    logic [1:0]          prod_r, prod_s;
    logic [CAMBIO_W-1:0] pend_r, pend_s;
    logic [2:0]          coin_r, coin_s;
    logic [MOT_W-1:0]    mot_cnt_r, mot_cnt_s;
    logic [TMO_W-1:0]    tmo_cnt_r, tmo_cnt_s;
    logic [2:0]          motor_en_r, motor_en_s;
    logic [2:0]          coin_eject_r, coin_eject_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                fault_r, fault_s;

    function automatic logic [2:0] prod_onehot(input logic [1:0] p);
        logic [2:0] oh;
        case (p)
            2'b01:   oh = 3'b001;
            2'b10:   oh = 3'b010;
            2'b11:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Next-state, datapath and next-output decode; coin one-hot doubles as its value.
    always_comb begin
        state_s   = state_r;
        prod_s    = prod_r;
        pend_s    = pend_r;
        coin_s    = coin_r;
        mot_cnt_s = mot_cnt_r;
        tmo_cnt_s = tmo_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.listo) begin
                    prod_s = bus.producto;
                    pend_s = bus.cambio;
                    if (bus.producto != 2'b00) begin
                        state_s   = ST_MOTOR;
                        mot_cnt_s = MOT_W'(MOTOR_CYCLES - 1);
                    end else begin
                        state_s = ST_SELECT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MOTOR: begin
                if (mot_cnt_r == {MOT_W{1'b0}}) begin
                    state_s = ST_SELECT;
                end else begin
                    mot_cnt_s = mot_cnt_r - MOT_W'(1);
                end
            end
            ST_SELECT: begin
                if (pend_r == {CAMBIO_W{1'b0}}) begin
                    state_s = ST_DONE;
                end else if ((pend_r >= CAMBIO_W'(4)) && !bus.hopper_empty[2]) begin
                    coin_s  = 3'b100;
                    state_s = ST_EJECT;
                end else if ((pend_r >= CAMBIO_W'(2)) && !bus.hopper_empty[1]) begin
                    coin_s  = 3'b010;
                    state_s = ST_EJECT;
                end else if (!bus.hopper_empty[0]) begin
                    coin_s  = 3'b001;
                    state_s = ST_EJECT;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            ST_EJECT: begin
                tmo_cnt_s = {TMO_W{1'b0}};
                state_s   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.coin_ack) begin
                    pend_s  = pend_r - CAMBIO_W'(coin_r);
                    state_s = ST_SELECT;
                end else if (tmo_cnt_r == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_s = ST_FAULT;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            ST_FAULT: begin
                if (bus.clear_fault) begin
                    pend_s  = {CAMBIO_W{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        motor_en_s   = (state_s == ST_MOTOR) ? prod_onehot(prod_s) : 3'b000;
        coin_eject_s = (state_s == ST_EJECT) ? coin_s : 3'b000;
        busy_s       = (state_s != ST_IDLE);
        done_s       = (state_s == ST_DONE);
        fault_s      = (state_s == ST_FAULT);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            prod_r       <= 2'b00;
            pend_r       <= {CAMBIO_W{1'b0}};
            coin_r       <= 3'b000;
            mot_cnt_r    <= {MOT_W{1'b0}};
            tmo_cnt_r    <= {TMO_W{1'b0}};
            motor_en_r   <= 3'b000;
            coin_eject_r <= 3'b000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            prod_r       <= prod_s;
            pend_r       <= pend_s;
            coin_r       <= coin_s;
            mot_cnt_r    <= mot_cnt_s;
            tmo_cnt_r    <= tmo_cnt_s;
            motor_en_r   <= motor_en_s;
            coin_eject_r <= coin_eject_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            fault_r      <= fault_s;
        end
    end

    assign bus.motor_en   = motor_en_r;
    assign bus.coin_eject = coin_eject_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.fault      = fault_r;
    assign bus.pendiente  = pend_r;

`ifdef COIN_COUNT_EN
    logic [7:0] coins_r;

    // Saturating count of coins confirmed by the hoppers; survives clear_fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            coins_r <= 8'd0;
        end else if ((state_r == ST_WAIT_ACK) && bus.coin_ack && (coins_r != 8'd255)) begin
            coins_r <= coins_r + 8'd1;
        end else begin
            coins_r <= coins_r;
        end
    end

    assign bus.coins_paid = coins_r;
`endif
endmodule
